scc_mapper_ctrl: RTL and testbench
==================================

Name: scc_mapper_ctrl

Overview:
Clocked controller that owns the four SCC/Konami-style 8 KB bank registers of the cartridge ROM mapper.
- Synchronises the asynchronous MSX slot strobes and decodes bank-select writes.
- Arbitrates bank-register updates between the MSX bus and a local configuration requester (USB-side controller) over a req/ack handshake.
- Drives the upper flash address for the current MSX access.

Parameters:
BANK_W, 6, width of each bank register and of address_upper.
SYNC_STAGES, 2, synchroniser depth on wr_n/sltsl_n; legal range 2..3.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sltsl_n  in  1  MSX slot select, asynchronous
wr_n  in  1  MSX write strobe, asynchronous
rd_n  in  1  MSX read strobe, asynchronous
addr_hi  in  5  MSX A15..A11
data  in  8  MSX data bus
cfg_req  in  1  local update request, level
cfg_idx  in  2  bank register index for local update
cfg_data  in  BANK_W  local bank value
cfg_ack  out  1  one-cycle grant/completion pulse
address_upper  out  BANK_W  flash A(BANK_W+12)..A13
rom_cs  out  1  flash chip-select qualifier, active high
bank_upd  out  1  one-cycle pulse on any bank-register change (either source)

Behaviour:
- Reset (async, reset_n low):
  - bank0..3 = 0,1,2,3.
  - cfg_ack = 0, bank_upd = 0, FSM = IDLE.
  - Synchroniser flops = 1 (inactive).
- Sync and edge detect:
  - wr_n and sltsl_n each pass through SYNC_STAGES flops, plus one history flop.
  - msx_evt = one-cycle pulse when synchronised wr_n goes 1→0 while synchronised sltsl_n = 0.
  - One event per strobe; a held-low strobe never re-fires.
- Capture: addr_hi and data are sampled on the msx_evt cycle. They are stable for the whole Z80 write cycle.
- Write decode (on msx_evt):
  - addr_hi = 01010 (5000–57FF) → bank0.
  - 01110 (7000–77FF) → bank1.
  - 10010 (9000–97FF) → bank2.
  - 10110 (B000–B7FF) → bank3.
  - Any other address: no change, no bank_upd.
  - Value written = data[BANK_W-1:0]; upper bits are dropped.
- MSX latency: the bank register holds the new value at clock edge SYNC_STAGES+1 after the pin falling edge is sampled. bank_upd pulses in that same cycle.
- Local handshake FSM:
  - IDLE: on cfg_req=1 and no msx_evt this cycle → write bank[cfg_idx]=cfg_data, assert cfg_ack (1 cycle), pulse bank_upd, go to RELEASE.
  - Collision: cfg_req=1 with msx_evt in the same cycle → MSX wins. Stay IDLE; the local request is served the next cycle if still requested.
  - RELEASE: wait for cfg_req=0, then go to IDLE. No second ack for a held request.
  - The requester must hold cfg_idx/cfg_data stable while cfg_req=1 until the ack.
  - MSX events are always served in every state.
- Read path (combinational from registers):
  - Page index {addr_hi[4], addr_hi[2]} selects the bank: 4000→bank0, 6000→bank1, 8000→bank2, A000→bank3.
  - rom_cs = ~sltsl_n & ~rd_n & (addr_hi in 4000–BFFF), raw asynchronous pins.
  - address_upper = selected bank when addr_hi is in 4000–BFFF, else 0.
- Reset mid-operation: all state returns to reset values immediately. Any pending local request is dropped and must be re-asserted after reset_n rises.

Optional Feature:
MAPPER_LOCK_EN
- Defined: adds input cfg_lock (1 bit). While cfg_lock=1, MSX bank-select writes are discarded (no bank change, no bank_upd); local updates still apply. This lets the host own the mapper during flash programming.
- Undefined: port absent; MSX writes are never blocked.

Decomposition:
- Package scc_mapper_pkg:
  - Bank-select window constants (5'b01010, 5'b01110, 5'b10010, 5'b10110).
  - Reset bank values.
  - FSM state enum {IDLE, RELEASE}.
- Sub-module msx_strobe_sync: SYNC_STAGES synchroniser plus falling-edge pulse generator, instantiated for wr_n. sltsl_n uses the synchroniser output only.

Test Plan:
1. Reset, then reads with sltsl_n=0, rd_n=0 at 4000/6000/8000/A000 → address_upper = 0,1,2,3, rom_cs=1. Read at C000 → address_upper=0, rom_cs=0.
2. MSX write 5000h data=0x0A (wr_n low 5 clk) → bank0=10 exactly SYNC_STAGES+1 clocks after the sampled edge, one bank_upd pulse. Read 4000h → 10. Write 0x4B to 9000h → bank2=0x0B (truncation).
3. MSX write 5800h and write with sltsl_n=1 to 7000h → no bank change, no bank_upd.
4. cfg_req with idx=3, data=0x2A → cfg_ack after one cycle, bank3=42. Hold cfg_req 4 more clocks → no second ack. Drop and re-raise → new ack.
5. cfg_req (idx=0, 0x11) raised in the same cycle as MSX event (5000h, 0x05) → bank0=0x05 that cycle, then 0x11 next cycle with cfg_ack. Two bank_upd pulses.
6. reset_n pulsed low during the RELEASE state and mid-strobe → banks back to 0..3, cfg_ack=0. With MAPPER_LOCK_EN and cfg_lock=1, MSX write 7000h=0x09 → bank1 unchanged.

Source files
------------

// File: rtl/scc_mapper_pkg.sv
// -----------------------------------------------------------------------------
// scc_mapper_pkg
// Shared constants and types for the SCC/Konami-style mapper controller.
//   - Bank-select write windows (MSX A15..A11 patterns).
//   - Bank register reset values.
//   - Local-update handshake FSM state type.
//   - Helper to decide whether an address lies in the 4000h-BFFFh ROM window.
// -----------------------------------------------------------------------------
package scc_mapper_pkg;

    localparam int NUM_BANKS = 4;

    // A15..A11 patterns of the bank-select write windows.
    localparam logic [4:0] WIN_BANK0 = 5'b01010;   // 5000h-57FFh
    localparam logic [4:0] WIN_BANK1 = 5'b01110;   // 7000h-77FFh
    localparam logic [4:0] WIN_BANK2 = 5'b10010;   // 9000h-97FFh
    localparam logic [4:0] WIN_BANK3 = 5'b10110;   // B000h-B7FFh

    localparam logic [4:0] BANK_WIN [NUM_BANKS] = '{WIN_BANK0, WIN_BANK1, WIN_BANK2, WIN_BANK3};

    // After reset the mapper presents the first 32 KB of flash linearly.
    localparam int BANK_RST [NUM_BANKS] = '{0, 1, 2, 3};

    typedef enum logic {
        IDLE    = 1'b0,
        RELEASE = 1'b1
    } cfg_state_e;

    // 4000h-BFFFh means A15..A14 is 01 or 10.
    function automatic logic in_rom_window(input logic [4:0] a_hi);
        return a_hi[4] ^ a_hi[3];
    endfunction

endpackage

// File: rtl/scc_mapper_ctrl_msx_strobe_sync.sv
// -----------------------------------------------------------------------------
// msx_strobe_sync
// Brings the asynchronous MSX write strobe and its slot-select qualifier into
// the clk domain and produces a single-cycle event on each qualified falling
// edge of the write strobe.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   strobe_n  in   asynchronous strobe (wr_n), edge detected
//   qual_n    in   asynchronous qualifier (sltsl_n), level only
//   evt       out  one-cycle pulse: synced strobe 1->0 while synced qual = 0
// SYNC_STAGES must be 2 or 3.
// -----------------------------------------------------------------------------
module msx_strobe_sync
    import scc_mapper_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_n,
    input  logic qual_n,
    output logic evt
);

    logic [SYNC_STAGES-1:0] strobe_sync_q, strobe_sync_d;
    logic [SYNC_STAGES-1:0] qual_sync_q,   qual_sync_d;
    logic                   strobe_hist_q, strobe_hist_d;

    always_comb begin
        strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], strobe_n};
        qual_sync_d   = {qual_sync_q[SYNC_STAGES-2:0],   qual_n};
        strobe_hist_d = strobe_sync_q[SYNC_STAGES-1];
    end

    // Reset to the inactive (high) level so release of reset never looks
    // like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_sync_q <= '1;
            qual_sync_q   <= '1;
            strobe_hist_q <= 1'b1;
        end else begin
            strobe_sync_q <= strobe_sync_d;
            qual_sync_q   <= qual_sync_d;
            strobe_hist_q <= strobe_hist_d;
        end
    end

    // A held-low strobe keeps the history flop low, so it fires only once.
    assign evt = strobe_hist_q & ~strobe_sync_q[SYNC_STAGES-1] & ~qual_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/scc_mapper_ctrl.sv
// -----------------------------------------------------------------------------
// scc_mapper_ctrl
// Owns the four 8 KB bank registers of an SCC/Konami-style ROM mapper.
// MSX bank-select writes (synchronised, edge detected) and a local req/ack
// configuration port both update the banks; MSX always wins a same-cycle
// collision and the local request is served one cycle later.
// The read path drives the upper flash address combinationally.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   sltsl_n, wr_n, rd_n     asynchronous MSX slot strobes
//   addr_hi[4:0], data[7:0] MSX A15..A11 and data bus
//   cfg_req/cfg_idx/cfg_data  local update request (level), index, value
//   cfg_lock                only with MAPPER_LOCK_EN: blocks MSX bank writes
//   cfg_ack                 one-cycle grant pulse for a local update
//   address_upper           flash A(BANK_W+12)..A13
//   rom_cs                  flash chip-select qualifier (active high)
//   bank_upd                one-cycle pulse on any bank-register write
// Build option: define MAPPER_LOCK_EN to add the cfg_lock input.
// -----------------------------------------------------------------------------
module scc_mapper_ctrl
    import scc_mapper_pkg::*;
#(
    parameter int BANK_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sltsl_n,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [4:0]        addr_hi,
    input  logic [7:0]        data,
    input  logic              cfg_req,
    input  logic [1:0]        cfg_idx,
    input  logic [BANK_W-1:0] cfg_data,
`ifdef MAPPER_LOCK_EN
    input  logic              cfg_lock,
`endif
    output logic              cfg_ack,
    output logic [BANK_W-1:0] address_upper,
    output logic              rom_cs,
    output logic              bank_upd
);

    logic                 msx_evt;
    logic                 msx_block;
    logic [NUM_BANKS-1:0] msx_hit;
    logic [NUM_BANKS-1:0] local_hit;
    logic                 local_go;
    logic [BANK_W-1:0]    msx_val;

    logic [BANK_W-1:0]    bank_q [NUM_BANKS];
    logic [BANK_W-1:0]    bank_d [NUM_BANKS];
    cfg_state_e           state_q, state_d;
    logic                 cfg_ack_q, cfg_ack_d;
    logic                 bank_upd_q, bank_upd_d;

    msx_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_n (wr_n),
        .qual_n   (sltsl_n),
        .evt      (msx_evt)
    );

`ifdef MAPPER_LOCK_EN
    assign msx_block = cfg_lock;
`else
    assign msx_block = 1'b0;
`endif

    // Upper data bits beyond the bank width are simply dropped.
    assign msx_val = BANK_W'(data);

    // Collision rule: any MSX event defers the local request by a cycle,
    // even when the event does not hit a bank window or is locked out.
    assign local_go = (state_q == IDLE) && cfg_req && !msx_evt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
            // addr_hi is stable across the Z80 write, so sampling it on the
            // event cycle is a valid capture.
            assign msx_hit[gi]   = msx_evt && !msx_block && (addr_hi == BANK_WIN[gi]);
            assign local_hit[gi] = local_go && (cfg_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = bank_q[i];
            if (msx_hit[i]) begin
                bank_d[i] = msx_val;
            end else if (local_hit[i]) begin
                bank_d[i] = cfg_data;
            end
        end

        cfg_ack_d  = local_go;
        bank_upd_d = (|msx_hit) | local_go;

        state_d = state_q;
        case (state_q)
            IDLE:    if (local_go) state_d = RELEASE;
            RELEASE: if (!cfg_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= BANK_W'(BANK_RST[i]);
            end
            state_q    <= IDLE;
            cfg_ack_q  <= 1'b0;
            bank_upd_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= bank_d[i];
            end
            state_q    <= state_d;
            cfg_ack_q  <= cfg_ack_d;
            bank_upd_q <= bank_upd_d;
        end
    end

    assign cfg_ack  = cfg_ack_q;
    assign bank_upd = bank_upd_q;

    // Read path: {A15, A13} picks the 8 KB page inside 4000h-BFFFh.
    logic       rom_win;
    logic [1:0] page;

    assign rom_win       = in_rom_window(addr_hi);
    assign page          = {addr_hi[4], addr_hi[2]};
    assign address_upper = rom_win ? bank_q[page] : '0;
    assign rom_cs        = ~sltsl_n & ~rd_n & rom_win;

endmodule

// File: tb/tb_scc_mapper_ctrl.sv
module tb_scc_mapper_ctrl;

    localparam int BANK_W = 6;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sltsl_n, wr_n, rd_n;
    logic [4:0]        addr_hi;
    logic [7:0]        data;
    logic              cfg_req;
    logic [1:0]        cfg_idx;
    logic [BANK_W-1:0] cfg_data;
    logic              cfg_ack;
    logic [BANK_W-1:0] address_upper;
    logic              rom_cs;
    logic              bank_upd;
`ifdef MAPPER_LOCK_EN
    logic              cfg_lock;
`endif

    scc_mapper_ctrl #(.BANK_W(BANK_W), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sltsl_n       (sltsl_n),
        .wr_n          (wr_n),
        .rd_n          (rd_n),
        .addr_hi       (addr_hi),
        .data          (data),
        .cfg_req       (cfg_req),
        .cfg_idx       (cfg_idx),
        .cfg_data      (cfg_data),
`ifdef MAPPER_LOCK_EN
        .cfg_lock      (cfg_lock),
`endif
        .cfg_ack       (cfg_ack),
        .address_upper (address_upper),
        .rom_cs        (rom_cs),
        .bank_upd      (bank_upd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int model [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = i;
    endtask

    // Flash page seen by the MSX at a 16-bit address: 8 KB pages from 4000h.
    function automatic int exp_upper(input int a16);
        if (a16 >= 'h4000 && a16 < 'hC000) return model[(a16 - 'h4000) >> 13];
        return 0;
    endfunction

    // Which bank a write to a16 selects, -1 if none.
    function automatic int win_idx(input int a16);
        if (a16 >= 'h5000 && a16 <= 'h57FF) return 0;
        if (a16 >= 'h7000 && a16 <= 'h77FF) return 1;
        if (a16 >= 'h9000 && a16 <= 'h97FF) return 2;
        if (a16 >= 'hB000 && a16 <= 'hB7FF) return 3;
        return -1;
    endfunction

    task automatic rd(input int a16, input bit sel_n, input bit r_n);
        bit cs_exp;
        @(negedge clk);
        addr_hi = 5'(a16 >> 11);
        sltsl_n = sel_n;
        rd_n    = r_n;
        #1;
        cs_exp = !sel_n && !r_n && a16 >= 'h4000 && a16 < 'hC000;
        chk("rd_addr_upper", address_upper, exp_upper(a16));
        chk("rd_rom_cs", rom_cs, cs_exp);
        $display("read  %04h sltsl_n=%0d rd_n=%0d -> upper=%0d cs=%0d", a16, sel_n, r_n, address_upper, rom_cs);
        rd_n    = 1'b1;
        sltsl_n = 1'b1;
    endtask

    // One MSX write; wr_n held low 5 clocks. address_upper reflects the
    // page of the write address, which for bank-select windows is the
    // targeted bank itself.
    task automatic msx_write(input int a16, input int d, input bit sel_n, input bit lock);
        int idx;
        idx = (sel_n || lock) ? -1 : win_idx(a16);
`ifdef MAPPER_LOCK_EN
        cfg_lock = lock;
`endif
        @(negedge clk);
        addr_hi = 5'(a16 >> 11);
        data    = 8'(d);
        sltsl_n = sel_n;
        wr_n    = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == SYNC + 1 && idx >= 0) model[idx] = d & ((1 << BANK_W) - 1);
            chk("msx_bank_upd", bank_upd, (k == SYNC + 1 && idx >= 0) ? 1 : 0);
            chk("msx_bank", address_upper, exp_upper(a16));
        end
        @(negedge clk);
        wr_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        sltsl_n = 1'b1;
        #1;
        chk("msx_no_upd_after", bank_upd, 0);
        $display("write %04h=%02h sltsl_n=%0d lock=%0d -> bank idx %0d", a16, d & 'hFF, sel_n, lock, idx);
`ifdef MAPPER_LOCK_EN
        cfg_lock = 1'b0;
`endif
    endtask

    task automatic local_upd(input int idx, input int d, input int hold);
        @(negedge clk);
        cfg_idx  = 2'(idx);
        cfg_data = BANK_W'(d);
        cfg_req  = 1'b1;
        @(posedge clk); #1;
        model[idx] = d & ((1 << BANK_W) - 1);
        chk("cfg_ack", cfg_ack, 1);
        chk("cfg_bank_upd", bank_upd, 1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("cfg_ack_held", cfg_ack, 0);
            chk("cfg_upd_held", bank_upd, 0);
        end
        @(negedge clk);
        cfg_req = 1'b0;
        @(posedge clk); #1;
        chk("cfg_ack_drop", cfg_ack, 0);
        $display("local bank%0d=%0d hold=%0d", idx, d, hold);
        rd('h4000 + idx * 'h2000, 1'b0, 1'b0);
    endtask

    initial begin
        int a16, d, idx, sel;
        int wbase [4];
        wbase = '{'h5000, 'h7000, 'h9000, 'hB000};

        reset_n = 1'b0; sltsl_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr_hi = '0; data = '0; cfg_req = 1'b0; cfg_idx = '0; cfg_data = '0;
`ifdef MAPPER_LOCK_EN
        cfg_lock = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_bank_upd", bank_upd, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1. reset mapping and read window
        rd('h4000, 1'b0, 1'b0);
        rd('h6000, 1'b0, 1'b0);
        rd('h8000, 1'b0, 1'b0);
        rd('hA000, 1'b0, 1'b0);
        rd('hC000, 1'b0, 1'b0);
        rd('h4000, 1'b1, 1'b0);

        // 2. MSX writes, including truncation
        msx_write('h5000, 'h0A, 1'b0, 1'b0);
        rd('h4000, 1'b0, 1'b0);
        msx_write('h9000, 'h4B, 1'b0, 1'b0);
        rd('h8000, 1'b0, 1'b0);

        // 3. outside window / slot not selected
        msx_write('h5800, 'h3C, 1'b0, 1'b0);
        msx_write('h7000, 'h15, 1'b1, 1'b0);
        rd('h6000, 1'b0, 1'b0);

        // 4. local handshake, held request, re-raise
        local_upd(3, 'h2A, 4);
        local_upd(3, 'h07, 0);

        // 5. collision: MSX wins, local served next cycle
        @(negedge clk);
        addr_hi = 5'('h5000 >> 11); data = 8'h05; sltsl_n = 1'b0; wr_n = 1'b0;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        cfg_idx = 2'd0; cfg_data = BANK_W'('h11); cfg_req = 1'b1;
        @(posedge clk); #1;
        model[0] = 'h05;
        chk("coll_msx_bank", address_upper, model[0]);
        chk("coll_msx_upd", bank_upd, 1);
        chk("coll_msx_ack", cfg_ack, 0);
        @(posedge clk); #1;
        model[0] = 'h11;
        chk("coll_cfg_bank", address_upper, model[0]);
        chk("coll_cfg_upd", bank_upd, 1);
        chk("coll_cfg_ack", cfg_ack, 1);
        @(posedge clk); #1;
        chk("coll_end_upd", bank_upd, 0);
        chk("coll_end_ack", cfg_ack, 0);
        $display("collision bank0 -> %0d", address_upper);
        @(negedge clk);
        cfg_req = 1'b0; wr_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        sltsl_n = 1'b1;

        // 6. reset during RELEASE and mid-strobe
        @(negedge clk);
        cfg_idx = 2'd2; cfg_data = BANK_W'(7); cfg_req = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_ack", cfg_ack, 1);
        @(negedge clk);
        addr_hi = 5'('h5000 >> 11); data = 8'h33; sltsl_n = 1'b0; wr_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_ack", cfg_ack, 0);
        chk("midrst_upd", bank_upd, 0);
        chk("midrst_bank0", address_upper, 0);
        $display("reset asserted mid-operation");
        @(negedge clk);
        wr_n = 1'b1; cfg_req = 1'b0; sltsl_n = 1'b1;
        rd('h6000, 1'b0, 1'b0);
        rd('h8000, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (SYNC + 3) @(posedge clk);
        #1;
        chk("postrst_upd", bank_upd, 0);
        rd('h4000, 1'b0, 1'b0);
        rd('hA000, 1'b0, 1'b0);

`ifdef MAPPER_LOCK_EN
        msx_write('h7000, 'h09, 1'b0, 1'b1);
        rd('h6000, 1'b0, 1'b0);
        local_upd(1, 'h21, 1);
`endif

        // Randomised mix against the model
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    if ($urandom_range(0, 3) != 0) begin
                        idx = $urandom_range(0, 3);
                        a16 = wbase[idx] + $urandom_range(0, 'h7FF);
                    end else begin
                        a16 = $urandom_range(0, 'hFFFF);
                    end
                    d   = $urandom_range(0, 255);
                    sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
                    msx_write(a16, d, sel[0], 1'b0);
                end
                1: local_upd($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 2));
                default: rd($urandom_range(0, 'hFFFF), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
